knight_combat_ctrl: RTL
=======================

// Module: knight_combat_ctrl
// PURPOSE
//  Sequences the Knight's attack (windup/active/recover) and arbitrates damage
//  requests from several hazard sources onto the single life counter.
//  Manages invulnerability frames after each hit.
//  Sits beside the player movement block, clocked by frame_clk.
//  Drives life/dead to the player and HUD, and attack_hitbox to boss collision.
// PARAMETERS
//  NUM_SRC        3      damage requesters (bit0 boss contact, bit1 projectile, bit2 pit fall)
//  LIFE_INIT      5      life loaded at reset (4-bit)
//  INVULN_FRAMES  60     frames of invulnerability after a granted hit (8-bit counter)
//  WINDUP_FRAMES  3      frames in WINDUP
//  ACTIVE_FRAMES  6      frames in ACTIVE (hitbox live)
//  RECOVER_FRAMES 8      frames in RECOVER
//  ATTACK_KEY     8'h1B  keycode that triggers an attack
// PORTS
//  frame_clk      in   1        frame clock, one edge per video frame
//  Reset          in   1        asynchronous, active-high
//  keycode        in   8        current keyboard code
//  hit_req        in   NUM_SRC  level damage requests; held until acked or dropped
//  hit_ack        out  NUM_SRC  one-hot, one-frame grant pulse
//  hurt           out  1        one-frame pulse on any grant
//  invuln         out  1        1 while invulnerability counter != 0
//  life           out  4        remaining life
//  dead           out  1        sticky; set when life reaches 0
//  attack_busy    out  1        attack FSM not IDLE (player forces status 4)
//  attack_hitbox  out  1        1 only in ACTIVE
// BEHAVIOUR
//  Reset (async): life=LIFE_INIT, dead=0, invuln cnt=0, FSM=IDLE, phase cnt=0.
//   Also hit_ack=0, hurt=0, rr_ptr=0, key_prev=0. All outputs are registered.
//  Press detect: press = (keycode==ATTACK_KEY) && !key_prev.
//   key_prev <= (keycode==ATTACK_KEY) every frame; a held key fires once.
//  Attack FSM (phase cnt reloads on each entry, counts down to 1):
//   IDLE    -> WINDUP on press && !dead && no grant this frame.
//   WINDUP  -> ACTIVE after WINDUP_FRAMES frames.
//   ACTIVE  -> RECOVER after ACTIVE_FRAMES frames.
//   RECOVER -> IDLE after RECOVER_FRAMES frames.
//   Press while not IDLE is ignored (no queuing).
//   Grant in any state forces IDLE next frame (stagger).
//  Damage arbitration, per frame:
//   Eligible when invuln cnt==0 and !dead. Round-robin from rr_ptr over
//   hit_req picks one source g; next frame hit_ack[g]=1, hurt=1, life-=1.
//   Then invuln cnt<=INVULN_FRAMES and rr_ptr<=(g+1) mod NUM_SRC.
//   Latency request->ack: 1 frame_clk edge.
//   Losers get no ack and must hold the request; they are re-arbitrated
//   only after invuln expires.
//   Invuln cnt decrements to 0 and saturates there.
//   A grant is possible on the same edge the counter reads 0.
//  Life arithmetic: 4-bit, decrement only on grant, never wraps below 0.
//   When the decrement yields 0: dead<=1 on that edge.
//  Dead: all later hit_ack=0, hurt=0, FSM held IDLE, presses ignored.
//   Leaves only via Reset.
//  Simultaneous press and grant: grant wins, the attack does not start.
//  Reset mid-attack or mid-invuln aborts immediately to reset values.
// TESTING
//  1 Reset, keycode=8'h1B held for 30 frames.
//    -> busy 17 frames, hitbox frames 4-9 after press, exactly one attack.
//  2 hit_req=3'b001 for 1 frame from idle.
//    -> next frame hit_ack=001, hurt=1, life 5->4, invuln=1 for 60 frames.
//  3 hit_req=3'b111 held with rr_ptr=0.
//    -> grants 001, then 010 after 61 frames, then 100; life 5->2.
//  4 Press, then hit_req=001 during ACTIVE.
//    -> hitbox drops next frame, FSM IDLE, life-1.
//  5 Press and hit_req=010 on the same frame.
//    -> ack 010, no attack; a new press after that starts WINDUP.
//  6 Five spaced hits -> life 0, dead=1; a 6th request gets no ack;
//    Reset mid-state -> life=5, dead=0.

Source files
------------

// File: rtl/knight_combat_ctrl.sv
// Knight combat controller: attack windup/active/recover sequencing plus
// round-robin damage arbitration onto the life counter with invulnerability frames.
module knight_combat_ctrl #(
    parameter int unsigned NUM_SRC        = 3,
    parameter int unsigned LIFE_INIT      = 5,
    parameter int unsigned INVULN_FRAMES  = 60,
    parameter int unsigned WINDUP_FRAMES  = 3,
    parameter int unsigned ACTIVE_FRAMES  = 6,
    parameter int unsigned RECOVER_FRAMES = 8,
    parameter logic [7:0]  ATTACK_KEY     = 8'h1B
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    input  logic [NUM_SRC-1:0] hit_req,
    output logic [NUM_SRC-1:0] hit_ack,
    output logic               hurt,
    output logic               invuln,
    output logic [3:0]         life,
    output logic               dead,
    output logic               attack_busy,
    output logic               attack_hitbox
);

    localparam int unsigned PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned LIFE_W  = 4;
    localparam int unsigned INV_W   = 8;
    localparam int unsigned PHASE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WINDUP  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RECOVER = 2'd3
    } atk_state_e;

    atk_state_e          state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [LIFE_W-1:0]   life_q, life_d;
    logic                dead_q, dead_d;
    logic [INV_W-1:0]    inv_cnt_q, inv_cnt_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                key_prev_q;
    logic [NUM_SRC-1:0]  hit_ack_q;
    logic                hurt_q;
    logic                invuln_q;
    logic                busy_q;
    logic                hitbox_q;

    logic                key_hit;
    logic                press;
    logic                eligible;
    logic                grant;
    logic [PTR_W-1:0]    grant_idx;
    logic [NUM_SRC-1:0]  grant_onehot;
    logic [PTR_W:0]      rr_sum;
    logic [PTR_W-1:0]    rr_idx;
    logic [PTR_W:0]      rr_after;

    assign key_hit = (keycode == ATTACK_KEY);
    assign press   = key_hit && !key_prev_q;

    // Round-robin pick starting at rr_ptr; only one grant while eligible.
    always_comb begin
        eligible     = (inv_cnt_q == '0) && !dead_q && (life_q != '0);
        grant        = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        rr_sum       = '0;
        rr_idx       = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (rr_sum >= (PTR_W+1)'(NUM_SRC)) begin
                rr_sum = rr_sum - (PTR_W+1)'(NUM_SRC);
            end
            rr_idx = rr_sum[PTR_W-1:0];
            if (eligible && !grant && hit_req[rr_idx]) begin
                grant     = 1'b1;
                grant_idx = rr_idx;
            end
        end
        if (grant) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    // Life, death, invulnerability and pointer updates.
    always_comb begin
        life_d    = life_q;
        dead_d    = dead_q;
        inv_cnt_d = inv_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        rr_after  = {1'b0, grant_idx} + (PTR_W+1)'(1);
        if (rr_after >= (PTR_W+1)'(NUM_SRC)) begin
            rr_after = '0;
        end
        if (grant) begin
            life_d    = life_q - LIFE_W'(1);
            dead_d    = dead_q || (life_q == LIFE_W'(1));
            inv_cnt_d = INV_W'(INVULN_FRAMES);
            rr_ptr_d  = rr_after[PTR_W-1:0];
        end else if (inv_cnt_q != '0) begin
            inv_cnt_d = inv_cnt_q - INV_W'(1);
        end
    end

    // Attack FSM next state; a grant or death staggers back to IDLE.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (dead_q || grant) begin
            state_d = ST_IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press) begin
                        state_d = ST_WINDUP;
                        phase_d = PHASE_W'(WINDUP_FRAMES);
                    end
                end
                ST_WINDUP: begin
                    if (phase_q <= PHASE_W'(1)) begin
                        state_d = ST_ACTIVE;
                        phase_d = PHASE_W'(ACTIVE_FRAMES);
                    end else begin
                        phase_d = phase_q - PHASE_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (phase_q <= PHASE_W'(1)) begin
                        state_d = ST_RECOVER;
                        phase_d = PHASE_W'(RECOVER_FRAMES);
                    end else begin
                        phase_d = phase_q - PHASE_W'(1);
                    end
                end
                ST_RECOVER: begin
                    if (phase_q <= PHASE_W'(1)) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q - PHASE_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            life_q     <= LIFE_W'(LIFE_INIT);
            dead_q     <= 1'b0;
            inv_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            key_prev_q <= 1'b0;
            hit_ack_q  <= '0;
            hurt_q     <= 1'b0;
            invuln_q   <= 1'b0;
            busy_q     <= 1'b0;
            hitbox_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            life_q     <= life_d;
            dead_q     <= dead_d;
            inv_cnt_q  <= inv_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            key_prev_q <= key_hit;
            hit_ack_q  <= grant_onehot;
            hurt_q     <= grant;
            invuln_q   <= (inv_cnt_d != '0);
            busy_q     <= (state_d != ST_IDLE);
            hitbox_q   <= (state_d == ST_ACTIVE);
        end
    end

    assign hit_ack       = hit_ack_q;
    assign hurt          = hurt_q;
    assign invuln        = invuln_q;
    assign life          = life_q;
    assign dead          = dead_q;
    assign attack_busy   = busy_q;
    assign attack_hitbox = hitbox_q;

endmodule
